// File: rtl/usb_pkg.sv
// usb_pkg: state encodings and ping-pong buffer geometry shared by the USB receive and transmit paths.
package usb_pkg;

    localparam int USB_BLOCK_LEN   = 126;
    localparam int USB_START_ADDR1 = 0;
    localparam int USB_START_ADDR2 = 126;

    typedef enum logic [2:0] {
        CHECK_RXF,
        RD_LOW,
        WRITE,
        RD_HIGH,
        BLOCK_DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_WR,
        ST_HIGH
    } strobe_e;

endpackage

// File: rtl/usb_fifo_receiver_if.sv
// usb_fifo_receiver_if: FT245 FIFO pins plus receive-buffer write port; master = the receiver.
interface usb_fifo_receiver_if;

    logic       ENA;
    logic       RXF;
    logic [7:0] D_USBRECV;
    logic       RD_USBRECV;
    logic       WCLK_USBBUFF;
    logic       WE_USBBUFF;
    logic [7:0] WADDR_USBBUFF;
    logic [7:0] D_USBBUFF;
    logic       BUFFREADY_USBRECV;
    logic       TIMEOUT_USBRECV;

    modport master (
        input  ENA, RXF, D_USBRECV,
        output RD_USBRECV, WCLK_USBBUFF, WE_USBBUFF, WADDR_USBBUFF, D_USBBUFF,
        output BUFFREADY_USBRECV, TIMEOUT_USBRECV
    );

    modport slave (
        output ENA, RXF, D_USBRECV,
        input  RD_USBRECV, WCLK_USBBUFF, WE_USBBUFF, WADDR_USBBUFF, D_USBBUFF,
        input  BUFFREADY_USBRECV, TIMEOUT_USBRECV
    );

endinterface

// File: rtl/usb_fifo_read_strobe.sv
// usb_fifo_read_strobe: RD# low/high timing for one FIFO read; sample_o marks the last low cycle, done_o the last high cycle.
module usb_fifo_read_strobe
    import usb_pkg::*;
#(
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic start_i,
    output logic rd_n_o,
    output logic sample_o,
    output logic done_o
);

    strobe_e    phase_q;
    logic [7:0] cnt_q;

    assign sample_o = (phase_q == ST_LOW) && (cnt_q == 8'(RD_LOW_CYC - 1));
    assign done_o   = (phase_q == ST_HIGH) && (cnt_q == 8'(RD_HIGH_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rd_n_o  <= 1'b1;
        end else begin
            case (phase_q)
                ST_IDLE: if (start_i) begin
                    rd_n_o  <= 1'b0;
                    cnt_q   <= 8'd0;
                    phase_q <= ST_LOW;
                end
                ST_LOW: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (sample_o) phase_q <= ST_WR;
                end
                ST_WR: begin
                    rd_n_o  <= 1'b1;
                    cnt_q   <= 8'd0;
                    phase_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (done_o) phase_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/usb_fifo_receiver.sv
// usb_fifo_receiver: drains an FT245-style USB FIFO into a 2-half ping-pong receive buffer.
// Define USB_RECV_TIMEOUT_EN to discard partial blocks after TIMEOUT_CYC idle cycles.
module usb_fifo_receiver
    import usb_pkg::*;
#(
    parameter int BLOCK_LEN   = USB_BLOCK_LEN,
    parameter int START_ADDR1 = USB_START_ADDR1,
    parameter int START_ADDR2 = USB_START_ADDR2,
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 2
`ifdef USB_RECV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65535
`endif
) (
    input logic CLK,
    input logic RST,
    usb_fifo_receiver_if.master bus
);

    rx_state_e  state_q;
    logic [7:0] cnt_q;
    logic [7:0] waddr_q;
    logic [7:0] data_q;
    logic       we_q;
    logic       bufrdy_q;
    logic       half_q;
    logic       start;
    logic       sample;
    logic       done;
    logic       rd_n;

    assign start = (state_q == CHECK_RXF) && bus.ENA && !bus.RXF;

    // The strobe runs in lockstep with RD_LOW/WRITE/RD_HIGH below.
    usb_fifo_read_strobe #(
        .RD_LOW_CYC (RD_LOW_CYC),
        .RD_HIGH_CYC(RD_HIGH_CYC)
    ) u_strobe (
        .CLK     (CLK),
        .RST     (RST),
        .start_i (start),
        .rd_n_o  (rd_n),
        .sample_o(sample),
        .done_o  (done)
    );

`ifdef USB_RECV_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        tmo_q;
    assign bus.TIMEOUT_USBRECV = tmo_q;
`else
    assign bus.TIMEOUT_USBRECV = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= CHECK_RXF;
            cnt_q    <= 8'd0;
            waddr_q  <= 8'(START_ADDR1);
            data_q   <= 8'd0;
            we_q     <= 1'b0;
            bufrdy_q <= 1'b0;
            half_q   <= 1'b1;
`ifdef USB_RECV_TIMEOUT_EN
            idle_q   <= 16'd0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                CHECK_RXF: if (start) state_q <= RD_LOW;
                RD_LOW: if (sample) begin
                    data_q  <= bus.D_USBRECV;
                    we_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: state_q <= RD_HIGH;
                RD_HIGH: if (done) begin
                    if (cnt_q == 8'(BLOCK_LEN - 1)) begin
                        state_q <= BLOCK_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        waddr_q <= waddr_q + 8'd1;
                        state_q <= CHECK_RXF;
                    end
                end
                BLOCK_DONE: begin
                    bufrdy_q <= half_q;
                    half_q   <= !half_q;
                    cnt_q    <= 8'd0;
                    waddr_q  <= half_q ? 8'(START_ADDR2) : 8'(START_ADDR1);
                    state_q  <= CHECK_RXF;
                end
            endcase
`ifdef USB_RECV_TIMEOUT_EN
            // Only counts while a partial block is parked; CHECK_RXF never touches cnt/waddr in the case above.
            tmo_q <= 1'b0;
            if ((state_q == CHECK_RXF) && !start && (cnt_q != 8'd0)) begin
                idle_q <= idle_q + 16'd1;
                if (idle_q == 16'(TIMEOUT_CYC - 1)) begin
                    idle_q  <= 16'd0;
                    cnt_q   <= 8'd0;
                    waddr_q <= half_q ? 8'(START_ADDR1) : 8'(START_ADDR2);
                    tmo_q   <= 1'b1;
                end
            end else begin
                idle_q <= 16'd0;
            end
`endif
        end
    end

    assign bus.RD_USBRECV        = rd_n;
    assign bus.WCLK_USBBUFF      = CLK;
    assign bus.WE_USBBUFF        = we_q;
    assign bus.WADDR_USBBUFF     = waddr_q;
    assign bus.D_USBBUFF         = data_q;
    assign bus.BUFFREADY_USBRECV = bufrdy_q;

endmodule

// File: tb/tb_usb_fifo_receiver.sv
// tb_usb_fifo_receiver: directed test of usb_fifo_receiver against an FT245 FIFO model and a write log.
module tb_usb_fifo_receiver;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rd_falls = 0;
    int   rd_ptr = 0;
    int   avail = 0;
    bit   pending = 1'b0;
    logic [7:0] mem [512];
    int   w_addr [$];
    int   w_data [$];
    int   w_cyc [$];

    usb_fifo_receiver_if bus ();

    usb_fifo_receiver dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // FIFO model: byte at rd_ptr is presented while RXF# is low, consumed when RD# returns high.
    always_comb begin
        bus.RXF       = (rd_ptr >= avail);
        bus.D_USBRECV = mem[rd_ptr];
    end
    always @(negedge bus.RD_USBRECV) begin
        rd_falls++;
        pending = 1'b1;
    end
    always @(posedge bus.RD_USBRECV) if (pending) begin
        pending = 1'b0;
        rd_ptr++;
    end

    always @(negedge CLK) if (bus.WE_USBBUFF === 1'b1) begin
        w_addr.push_back(int'(bus.WADDR_USBBUFF));
        w_data.push_back(int'(bus.D_USBBUFF));
        w_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int t0, rise, lb, rb, errs;
        bus.ENA = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_rd", bus.RD_USBRECV, 1);
        check("rst_we", bus.WE_USBBUFF, 0);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        check("idle_rd", bus.RD_USBRECV, 1);
        check("idle_we", bus.WE_USBBUFF, 0);
        check("idle_waddr", bus.WADDR_USBBUFF, 0);
        check("idle_dout", bus.D_USBBUFF, 0);
        check("idle_bufrdy", bus.BUFFREADY_USBRECV, 0);
        check("idle_tmo", bus.TIMEOUT_USBRECV, 0);
        check("idle_writes", w_addr.size(), 0);
        check("idle_rdfalls", rd_falls, 0);

        // Two full blocks back to back: 0x00..0x7D then 0x80..0xFD.
        for (int i = 0; i < 126; i++) begin
            mem[i]       = 8'(i);
            mem[126 + i] = 8'(8'h80 + i);
        end
        t0 = cyc;
        avail = 252;
        rise = -1;
        for (int k = 0; k < 3000 && bus.BUFFREADY_USBRECV !== 1'b1; k++) @(negedge CLK);
        rise = cyc;
        check("blk1_bufrdy", bus.BUFFREADY_USBRECV, 1);
        check("blk1_waddr_next", bus.WADDR_USBBUFF, 126);
        check("blk1_writes", w_addr.size(), 126);
        check("first_latency", w_cyc[0] - t0, 5);
        check("bufrdy_rise_delay", rise - w_cyc[125], 4);
        for (int k = 0; k < 3000 && bus.BUFFREADY_USBRECV !== 1'b0; k++) @(negedge CLK);
        check("blk2_bufrdy", bus.BUFFREADY_USBRECV, 0);
        check("blk2_waddr_wrap", bus.WADDR_USBBUFF, 0);
        repeat (20) @(negedge CLK);
        check("blk2_writes", w_addr.size(), 252);
        check("blk2_waddr_idle", bus.WADDR_USBBUFF, 0);
        check("blk2_consumed", rd_ptr, 252);
        errs = 0;
        for (int i = 0; i < 252 && i < w_addr.size(); i++)
            if (w_addr[i] != i || w_data[i] != (i < 126 ? i : 8'h80 + i - 126)) errs++;
        check("blk12_addr_data_errs", errs, 0);
        errs = 0;
        for (int i = 1; i < 252 && i < w_cyc.size(); i++)
            if (i != 126 && w_cyc[i] - w_cyc[i - 1] != 8) errs++;
        check("byte_period_errs", errs, 0);

        // ENA dropped during RD_LOW of byte 10 of a fresh block.
        lb = w_addr.size();
        rb = rd_falls;
        for (int i = 0; i < 11; i++) mem[252 + i] = 8'(8'h40 + i);
        avail = 263;
        for (int k = 0; k < 500 && rd_falls < rb + 10; k++) @(negedge CLK);
        bus.ENA = 1'b0;
        repeat (60) @(negedge CLK);
        check("ena_writes", w_addr.size() - lb, 10);
        check("ena_last_addr", w_addr[w_addr.size() - 1], 9);
        check("ena_last_data", w_data[w_data.size() - 1], 8'h49);
        check("ena_rdfalls", rd_falls - rb, 10);
        check("ena_rd_high", bus.RD_USBRECV, 1);
        check("ena_waddr_hold", bus.WADDR_USBBUFF, 10);
        bus.ENA = 1'b1;
        for (int k = 0; k < 100 && w_addr.size() < lb + 11; k++) @(negedge CLK);
        check("reena_addr", w_addr[w_addr.size() - 1], 10);
        check("reena_data", w_data[w_data.size() - 1], 8'h4A);

        // Finish half 1 (115 bytes), 49 bytes into half 2, then reset in RD_LOW of byte 50.
        repeat (10) @(negedge CLK);
        lb = w_addr.size();
        rb = rd_falls;
        for (int i = 0; i < 166; i++) mem[263 + i] = 8'((i * 7 + 3) & 255);
        avail = 429;
        for (int k = 0; k < 3000 && rd_falls < rb + 165; k++) @(negedge CLK);
        check("pre_rst_bufrdy", bus.BUFFREADY_USBRECV, 1);
        check("pre_rst_writes", w_addr.size() - lb, 164);
        check("pre_rst_last_addr", w_addr[w_addr.size() - 1], 174);
        check("pre_rst_last_data", w_data[w_data.size() - 1], (163 * 7 + 3) & 255);
        check("pre_rst_rd_low", bus.RD_USBRECV, 0);
        RST = 1'b1;
        #1;
        check("rst_async_rd", bus.RD_USBRECV, 1);
        check("rst_bufrdy", bus.BUFFREADY_USBRECV, 0);
        check("rst_waddr", bus.WADDR_USBBUFF, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 100 && w_addr.size() < lb + 165; k++) @(negedge CLK);
        check("post_rst_writes", w_addr.size() - lb, 165);
        check("post_rst_addr", w_addr[w_addr.size() - 1], 0);
        check("post_rst_data", w_data[w_data.size() - 1], (165 * 7 + 3) & 255);
        check("post_rst_bufrdy", bus.BUFFREADY_USBRECV, 0);
        check("end_tmo", bus.TIMEOUT_USBRECV, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_fifo_receiver.md
Name: usb_fifo_receiver

Overview:
Host-to-device counterpart of the USB transmit path. Drains bytes from the FT245-style USB FIFO (RXF#/RD#/D) and writes them into a 2-half ping-pong receive buffer (half 1 at address 0, half 2 at address 126, 126 bytes each). A level flag tells the downstream command parser which half is complete. Sits between the USB FIFO pins and the receive buffer RAM write port.

Parameters:
BLOCK_LEN, 126, bytes per half-buffer.
START_ADDR1, 0, base write address of half 1.
START_ADDR2, 126, base write address of half 2.
RD_LOW_CYC, 4, CLK cycles RD# is held low before D is sampled (min 1).
RD_HIGH_CYC, 2, CLK cycles RD# is held high after a read before RXF# is rechecked (min 1).
TIMEOUT_CYC, 65535, idle cycles before a partial block is discarded (only with USB_RECV_TIMEOUT_EN).

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous, active-high reset.
ENA  input  1  receive enable; low = no new byte reads started.
RXF  input  1  FIFO data available, active-low.
D_USBRECV  input  8  FIFO data bus.
RD_USBRECV  output  1  FIFO read strobe, active-low.
WCLK_USBBUFF  output  1  buffer write clock (= CLK).
WE_USBBUFF  output  1  buffer write enable, 1-cycle pulse per byte.
WADDR_USBBUFF  output  8  buffer write address.
D_USBBUFF  output  8  buffer write data.
BUFFREADY_USBRECV  output  1  1 = half 1 complete, 0 = half 2 complete (level, toggles per block).
TIMEOUT_USBRECV  output  1  1-cycle pulse when a partial block is discarded (tied 0 without the feature).

Behaviour:
- Reset values: RD_USBRECV=1, WE_USBBUFF=0, WADDR_USBBUFF=START_ADDR1, D_USBBUFF=0, BUFFREADY_USBRECV=0, TIMEOUT_USBRECV=0, half select=1, byte count=0, state=CHECK_RXF. All outputs registered.
- States:
  - CHECK_RXF: if ENA=1 and RXF=0, then RD_USBRECV<=0 and go to RD_LOW. Otherwise stay.
  - RD_LOW: count RD_LOW_CYC cycles with RD#=0. On the last cycle, latch D_USBRECV into D_USBBUFF and go to WRITE.
  - WRITE: WE_USBBUFF=1 for exactly one cycle at WADDR_USBBUFF; RD_USBRECV<=1; go to RD_HIGH.
  - RD_HIGH: count RD_HIGH_CYC cycles with RD#=1. Then:
    - If byte count = BLOCK_LEN-1: go to BLOCK_DONE.
    - Else: increment address and count, go to CHECK_RXF.
  - BLOCK_DONE (1 cycle):
    - BUFFREADY_USBRECV <= 1 if half 1 just filled, 0 if half 2 just filled.
    - Toggle half select; count <= 0; WADDR <= base of new half; go to CHECK_RXF.
- Byte latency: RXF# low to WE pulse = RD_LOW_CYC+1 cycles (RXF sampled directly; upstream synchroniser assumed present). Byte period = RD_LOW_CYC+RD_HIGH_CYC+2 cycles.
- RXF# rising during RD_LOW is ignored; the byte in flight completes.
- ENA falling mid-byte: the current byte completes (RD_LOW/WRITE/RD_HIGH/BLOCK_DONE). The FSM then holds in CHECK_RXF, with count and address preserved.
- Address never exceeds base+BLOCK_LEN-1. Wrap happens only through BLOCK_DONE. Address arithmetic is 8-bit unsigned; START_ADDR2+BLOCK_LEN must be ≤ 256.
- No overrun detection: the downstream parser must consume a half within one block time.
- RST asserted mid-byte: RD# deasserts immediately (async). The partial block is lost; the next block starts at half 1.

Optional Feature:
USB_RECV_TIMEOUT_EN
- Defined: an idle counter runs while in CHECK_RXF with count ≠ 0. It clears on any byte read.
  - When it reaches TIMEOUT_CYC: count <= 0, WADDR <= base of current half, TIMEOUT_USBRECV pulses 1 cycle.
  - BUFFREADY and half select are unchanged.
- Undefined: no counter; TIMEOUT_USBRECV tied 0; a partial block waits indefinitely.

Decomposition:
- Shared package usb_pkg: state encoding constants, START_ADDR1/START_ADDR2/BLOCK_LEN defaults (also used by the transmit side).
- One sub-module, usb_fifo_read_strobe: RD# timing generator (RD_LOW/RD_HIGH counters). Inputs start; outputs RD#, sample pulse, done pulse. Block-level FSM stays in the top.

Test Plan:
- Reset with RXF=1, ENA=1 for 100 cycles -> RD#=1, WE=0, WADDR=0, BUFFREADY=0.
- FIFO model supplies 126 bytes 0x00..0x7D, RD_LOW_CYC=4, RD_HIGH_CYC=2 -> 126 WE pulses at addresses 0..125 with matching data, 8 cycles apart. BUFFREADY rises 1 cycle after the last RD_HIGH; next WADDR=126.
- Continue with 126 more bytes 0x80..0xFD -> writes to 126..251; BUFFREADY falls to 0; WADDR returns to 0.
- ENA dropped during the RD_LOW of byte 10 -> byte 10 is written at address 9, no further RD# pulses. Re-enable -> byte 11 goes to address 10.
- RST pulsed during the RD_LOW of byte 50 in half 2 -> RD#=1 immediately; after release the next byte goes to address 0, BUFFREADY=0.
- With USB_RECV_TIMEOUT_EN, TIMEOUT_CYC=100: 5 bytes, then RXF=1 for 100 cycles -> TIMEOUT pulse; the next byte goes to address 0; BUFFREADY unchanged.
